motor_pwm_decode: RTL and testbench

Recovers the signed drive command from one motor channel's PWM pair (fwd, rev), the inverse of the motor controller's command-to-PWM conversion. It integrates the high time of each line over a fixed window of exactly one PWM period and reports a signed duty value plus brake and fault flags once per window. It sits on the motor output side for closed-loop self-check and for bench scoreboarding of the motor controller. Instantiate one per motor channel.

---
 rtl/motor_pwm_decode.sv | 113 +++++++++++
 tb/tb_motor_pwm_decode.sv | 283 ++++++++++++++++++++++++++++
 2 files changed

// File: rtl/motor_pwm_decode.sv
// Recovers the signed drive command from one motor channel's fwd/rev PWM pair by integrating
// each line's high time over a free-running window of exactly one PWM period.
module motor_pwm_decode #(
    parameter int unsigned MAG_W = 10
) (
    input  logic           clk,
    input  logic           rst,
    input  logic           fwd_i,
    input  logic           rev_i,
    output logic [MAG_W:0] duty_o,
    output logic           valid_o,
    output logic           brake_o,
    output logic           fault_o
);

    localparam int unsigned CntW  = MAG_W + 1;
    localparam int unsigned DiffW = MAG_W + 2;

    localparam logic [MAG_W-1:0] WinLast = {MAG_W{1'b1}};
    localparam logic [MAG_W-1:0] WinOne  = {{(MAG_W-1){1'b0}}, 1'b1};
    localparam logic [CntW-1:0]  Period  = {1'b1, {MAG_W{1'b0}}};
    localparam logic [MAG_W:0]   DutyMax = {1'b0, {MAG_W{1'b1}}};
    localparam logic [MAG_W:0]   DutyMin = {1'b1, {MAG_W{1'b0}}};

    logic             f_q, r_q;
    logic [MAG_W-1:0] win_cnt_q, win_cnt_d;
    logic [CntW-1:0]  f_cnt_q, f_cnt_d;
    logic [CntW-1:0]  r_cnt_q, r_cnt_d;
    logic [CntW-1:0]  b_cnt_q, b_cnt_d;
    logic [MAG_W:0]   duty_q, duty_d;
    logic             valid_q, valid_d;
    logic             brake_q, brake_d;
    logic             fault_q, fault_d;

    logic [CntW-1:0]  f_sum, r_sum, b_sum;
    logic [DiffW-1:0] diff;
    logic [MAG_W:0]   duty_sat;
    logic             terminal;

    always_comb begin
        // Sums include the current sample so the terminal cycle is part of its own window.
        f_sum = f_cnt_q + {{MAG_W{1'b0}}, f_q & ~r_q};
        r_sum = r_cnt_q + {{MAG_W{1'b0}}, r_q & ~f_q};
        b_sum = b_cnt_q + {{MAG_W{1'b0}}, f_q & r_q};
        diff  = {1'b0, f_sum} - {1'b0, r_sum};

        case (diff[DiffW-1:DiffW-2])
            2'b01:   duty_sat = DutyMax;
            2'b10:   duty_sat = DutyMin;
            default: duty_sat = diff[MAG_W:0];
        endcase
    end

    always_comb begin
        terminal  = (win_cnt_q == WinLast);
        win_cnt_d = win_cnt_q + WinOne;
        f_cnt_d   = f_sum;
        r_cnt_d   = r_sum;
        b_cnt_d   = b_sum;
        duty_d    = duty_q;
        valid_d   = 1'b0;
        brake_d   = brake_q;
        fault_d   = fault_q;

        if (terminal) begin
            f_cnt_d = '0;
            r_cnt_d = '0;
            b_cnt_d = '0;
            valid_d = 1'b1;
            if (b_sum == Period) begin
                brake_d = 1'b1;
                fault_d = 1'b0;
                duty_d  = '0;
            end else begin
                brake_d = 1'b0;
                fault_d = (b_sum != '0);
                duty_d  = duty_sat;
            end
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            f_q       <= 1'b0;
            r_q       <= 1'b0;
            win_cnt_q <= '0;
            f_cnt_q   <= '0;
            r_cnt_q   <= '0;
            b_cnt_q   <= '0;
            duty_q    <= '0;
            valid_q   <= 1'b0;
            brake_q   <= 1'b0;
            fault_q   <= 1'b0;
        end else begin
            f_q       <= fwd_i;
            r_q       <= rev_i;
            win_cnt_q <= win_cnt_d;
            f_cnt_q   <= f_cnt_d;
            r_cnt_q   <= r_cnt_d;
            b_cnt_q   <= b_cnt_d;
            duty_q    <= duty_d;
            valid_q   <= valid_d;
            brake_q   <= brake_d;
            fault_q   <= fault_d;
        end
    end

    assign duty_o  = duty_q;
    assign valid_o = valid_q;
    assign brake_o = brake_q;
    assign fault_o = fault_q;

endmodule

// File: tb/tb_motor_pwm_decode.sv
// Bench for motor_pwm_decode: drives PWM patterns, queues expected window results and
// checks each valid pulse, its spacing/width and output hold between windows.
module tb_motor_pwm_decode;

    localparam int unsigned MAG_W  = 10;
    localparam int          PERIOD = 1024;

    logic           clk;
    logic           rst;
    logic           fwd_i;
    logic           rev_i;
    logic [MAG_W:0] duty_o;
    logic           valid_o;
    logic           brake_o;
    logic           fault_o;

    motor_pwm_decode #(.MAG_W(MAG_W)) dut (
        .clk     (clk),
        .rst     (rst),
        .fwd_i   (fwd_i),
        .rev_i   (rev_i),
        .duty_o  (duty_o),
        .valid_o (valid_o),
        .brake_o (brake_o),
        .fault_o (fault_o)
    );

    typedef struct {
        logic chk;
        int   lo;
        int   hi;
        logic brake;
        logic fault;
    } exp_t;

    typedef struct {
        int   f_hi;
        int   r_hi;
        int   r_off;
        int   duty;
        logic brake;
        logic fault;
    } vec_t;

    exp_t sb[$];
    vec_t vecs[10];

    int n_checks = 0;
    int n_errors = 0;

    // PWM generator state, shared with the driver process.
    int ph    = 37;
    int f_hi  = PERIOD;
    int r_hi  = 0;
    int r_off = 0;

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    initial begin
        fwd_i = 1'b0;
        rev_i = 1'b0;
        forever begin
            @(posedge clk);
            #1;
            fwd_i = (ph < f_hi);
            rev_i = (((ph - r_off + PERIOD) % PERIOD) < r_hi);
            ph    = (ph + 1) % PERIOD;
        end
    end

    // Monitor: pops the scoreboard on valid, checks pulse width, spacing and hold.
    initial begin
        int   cyc = 0;
        int   last_v = -1;
        int   win = 0;
        int   d;
        logic prev_valid = 1'b0;
        logic [MAG_W:0] hold_duty = '0;
        logic hold_brake = 1'b0;
        logic hold_fault = 1'b0;
        exp_t e;
        forever begin
            @(negedge clk);
            cyc++;
            if (rst) begin
                last_v     = -1;
                prev_valid = 1'b0;
                hold_duty  = '0;
                hold_brake = 1'b0;
                hold_fault = 1'b0;
                continue;
            end
            if (valid_o) begin
                win++;
                n_checks++;
                if (prev_valid) begin
                    n_errors++;
                    $display("FAIL valid_width win%0d: valid high 2 cycles, want 1", win);
                end
                if (last_v >= 0) begin
                    n_checks++;
                    if (cyc - last_v != PERIOD) begin
                        n_errors++;
                        $display("FAIL valid_spacing win%0d: got %0d cycles, want %0d",
                                 win, cyc - last_v, PERIOD);
                    end
                end
                last_v = cyc;
                if (sb.size() != 0) begin
                    e = sb.pop_front();
                    if (e.chk) begin
                        d = $signed(duty_o);
                        n_checks += 3;
                        if (d < e.lo || d > e.hi) begin
                            n_errors++;
                            $display("FAIL duty win%0d: got %0d, want %0d..%0d",
                                     win, d, e.lo, e.hi);
                        end
                        if (brake_o !== e.brake) begin
                            n_errors++;
                            $display("FAIL brake win%0d: got %b, want %b", win, brake_o, e.brake);
                        end
                        if (fault_o !== e.fault) begin
                            n_errors++;
                            $display("FAIL fault win%0d: got %b, want %b", win, fault_o, e.fault);
                        end
                    end
                end
                hold_duty  = duty_o;
                hold_brake = brake_o;
                hold_fault = fault_o;
            end else begin
                n_checks++;
                if (duty_o !== hold_duty || brake_o !== hold_brake || fault_o !== hold_fault) begin
                    n_errors++;
                    $display("FAIL hold cyc%0d: got %0d/%b/%b, want %0d/%b/%b", cyc,
                             $signed(duty_o), brake_o, fault_o,
                             $signed(hold_duty), hold_brake, hold_fault);
                end
            end
            prev_valid = valid_o;
        end
    end

    task automatic push_exp(input logic chk, input int lo, input int hi,
                            input logic brk, input logic flt);
        exp_t e;
        e.chk   = chk;
        e.lo    = lo;
        e.hi    = hi;
        e.brake = brk;
        e.fault = flt;
        sb.push_back(e);
    endtask

    task automatic wait_empty(input int budget);
        int n = 0;
        while (sb.size() != 0 && n < budget) begin
            @(negedge clk);
            n++;
        end
        if (sb.size() != 0) begin
            n_checks++;
            n_errors++;
            $display("FAIL timeout: %0d results pending after %0d cycles, want 0", sb.size(), n);
            sb.delete();
        end
    endtask

    task automatic check_idle(input string name);
        n_checks += 4;
        if (duty_o !== '0) begin
            n_errors++;
            $display("FAIL %s_duty: got %0d, want 0", name, $signed(duty_o));
        end
        if (valid_o !== 1'b0) begin
            n_errors++;
            $display("FAIL %s_valid: got %b, want 0", name, valid_o);
        end
        if (brake_o !== 1'b0) begin
            n_errors++;
            $display("FAIL %s_brake: got %b, want 0", name, brake_o);
        end
        if (fault_o !== 1'b0) begin
            n_errors++;
            $display("FAIL %s_fault: got %b, want 0", name, fault_o);
        end
    endtask

    // Called right after rst falls; the first valid follows PERIOD+1 cycles later.
    task automatic check_first_valid(input string name);
        int n = 0;
        while (n < PERIOD + 100) begin
            @(negedge clk);
            n++;
            if (valid_o) break;
        end
        n_checks++;
        if (n != PERIOD + 1) begin
            n_errors++;
            $display("FAIL %s_latency: got %0d cycles, want %0d", name, n, PERIOD + 1);
        end
    endtask

    initial begin
        vecs[0] = '{256,    0,    0,   256,  1'b0, 1'b0};
        vecs[1] = '{0,      768,  0,   -768, 1'b0, 1'b0};
        vecs[2] = '{0,      1024, 0,   -1024, 1'b0, 1'b0};
        vecs[3] = '{1024,   1024, 0,   0,    1'b1, 1'b0};
        vecs[4] = '{1024,   100,  0,   924,  1'b0, 1'b1};
        vecs[5] = '{0,      0,    0,   0,    1'b0, 1'b0};
        vecs[6] = '{512,    512,  512, 0,    1'b0, 1'b0};
        vecs[7] = '{1000,   24,   1000, 976, 1'b0, 1'b0};
        vecs[8] = '{1024,   0,    0,   1023, 1'b0, 1'b0};
        vecs[9] = '{512,    0,    0,   512,  1'b0, 1'b0};

        // Constant fwd from reset: first window misses one sample, later ones clamp.
        rst = 1'b1;
        repeat (3) @(posedge clk);
        #1;
        check_idle("reset");
        push_exp(1'b1, 1023, 1023, 1'b0, 1'b0);
        push_exp(1'b1, 1023, 1023, 1'b0, 1'b0);
        rst = 1'b0;
        check_first_valid("first");
        wait_empty(3 * PERIOD);

        // Each pattern: one transitional window skipped, the next fully steady.
        for (int i = 0; i < 10; i++) begin
            f_hi  = vecs[i].f_hi;
            r_hi  = vecs[i].r_hi;
            r_off = vecs[i].r_off;
            push_exp(1'b0, 0, 0, 1'b0, 1'b0);
            push_exp(1'b1, vecs[i].duty, vecs[i].duty, vecs[i].brake, vecs[i].fault);
            wait_empty(3 * PERIOD);
        end

        // Reset mid-window with 50% fwd running: outputs clear at once, partial window dropped.
        repeat (500) @(posedge clk);
        #1;
        rst = 1'b1;
        #1;
        check_idle("midreset");
        sb.delete();
        repeat (3) @(posedge clk);
        #1;
        rst = 1'b0;
        push_exp(1'b1, 511, 512, 1'b0, 1'b0);
        check_first_valid("midreset");
        wait_empty(3 * PERIOD);

        // Step 256 fwd -> 768 rev mid-window, with the PWM phase pinned to the window.
        f_hi  = 256;
        r_hi  = 0;
        r_off = 0;
        push_exp(1'b0, 0, 0, 1'b0, 1'b0);
        wait_empty(3 * PERIOD);
        ph = 924;
        push_exp(1'b0, 0, 0, 1'b0, 1'b0);
        wait_empty(3 * PERIOD);
        push_exp(1'b1, -128, -128, 1'b0, 1'b0);
        push_exp(1'b1, -768, -768, 1'b0, 1'b0);
        repeat (412) @(negedge clk);
        f_hi = 0;
        r_hi = 768;
        ph   = 384;
        wait_empty(3 * PERIOD);

        repeat (5) @(negedge clk);
        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

    initial begin
        #900000;
        $display("FAIL watchdog: simulation did not complete within time limit");
        $fatal(1, "watchdog expired");
    end

endmodule
